// File: rtl/seq_det_param.sv
// Parametrised Mealy serial pattern detector with run-time pattern load and saturating match counter.
// Define SEQ_DET_REG_OUT_EN to register y (one clock of latency); by default y is combinational.
//
// state | meaning
// ------+-------------------------------------------------------------
// HUNT  | fewer than PAT_W-1 bits accepted since the last restart
// ARMED | history holds PAT_W-1 bits; the next accepted bit may match
module seq_det_param #(
    parameter int unsigned       PAT_W   = 4,
    parameter logic [PAT_W-1:0]  PAT_RST = 4'b1010,
    parameter int unsigned       CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             x_valid,
    input  logic             x,
    input  logic             overlap,
    input  logic             load,
    input  logic [PAT_W-1:0] pat_in,
    input  logic             clr_cnt,
    output logic             y,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cnt_sat
);

    localparam int unsigned      FW       = $clog2(PAT_W);
    localparam logic [FW-1:0]    FILL_MAX = FW'(PAT_W - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic {HUNT = 1'b0, ARMED = 1'b1} state_t;

    state_t             state_q, state_d;
    logic [PAT_W-1:0]   pat_q, pat_d;
    logic [PAT_W-2:0]   hist_q, hist_d;
    logic [FW-1:0]      fill_q, fill_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sat_q, sat_d;

    logic               accept;
    logic               match;
    logic [PAT_W-1:0]   window;

    // The full window doubles as the shifted history: its low PAT_W-1 bits are the next hist.
    assign window = {hist_q, x};
    assign accept = x_valid & ~load;
    assign match  = (state_q == ARMED) && accept && (window == pat_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= HUNT;
            pat_q   <= PAT_RST;
            hist_q  <= '0;
            fill_q  <= '0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        cnt_d   = cnt_q;

        if (load) begin
            pat_d   = pat_in;
            hist_d  = '0;
            fill_d  = '0;
            state_d = HUNT;
        end else if (accept) begin
            if (match && !overlap) begin
                hist_d  = '0;
                fill_d  = '0;
                state_d = HUNT;
            end else begin
                hist_d  = window[PAT_W-2:0];
                fill_d  = (fill_q == FILL_MAX) ? fill_q : fill_q + FW'(1);
                state_d = (fill_d == FILL_MAX) ? ARMED : HUNT;
            end
        end

        // A clear beats a coincident match; that match is dropped from the count.
        if (clr_cnt) begin
            cnt_d = '0;
        end else if (match && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        sat_d = (cnt_d == CNT_MAX);
    end

    assign match_cnt = cnt_q;
    assign cnt_sat   = sat_q;

`ifdef SEQ_DET_REG_OUT_EN
    logic y_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            y_q <= 1'b0;
        end else begin
            y_q <= match;
        end
    end

    assign y = y_q;
`else
    assign y = match;
`endif

endmodule

// File: tb/tb_seq_det_param.sv
// Directed bench for seq_det_param: default-width instance plus a CNT_W=2 instance on the same stream.
module tb_seq_det_param;

    logic       clk = 1'b0;
    logic       rst;
    logic       x_valid;
    logic       x;
    logic       overlap;
    logic       load;
    logic [3:0] pat_in;
    logic       clr_cnt;

    logic       y;
    logic [7:0] match_cnt;
    logic       cnt_sat;
    logic       y2;
    logic [1:0] cnt2;
    logic       sat2;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    seq_det_param dut (
        .clk(clk), .rst(rst), .x_valid(x_valid), .x(x), .overlap(overlap),
        .load(load), .pat_in(pat_in), .clr_cnt(clr_cnt),
        .y(y), .match_cnt(match_cnt), .cnt_sat(cnt_sat)
    );

    seq_det_param #(.CNT_W(2)) dut_c2 (
        .clk(clk), .rst(rst), .x_valid(x_valid), .x(x), .overlap(overlap),
        .load(load), .pat_in(pat_in), .clr_cnt(clr_cnt),
        .y(y2), .match_cnt(cnt2), .cnt_sat(sat2)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one cycle, check y mid-cycle, then advance to just after the next rising edge.
    task automatic bit_in(input logic v, input logic b, input logic exp_y, input string tag);
        x_valid = v;
        x       = b;
        @(negedge clk);
        check_val(tag, {31'd0, y}, {31'd0, exp_y});
        @(posedge clk);
        #1;
    endtask

    // bits/exp are MSB-first: bit n-1 is sent first.
    task automatic run_bits(input logic [15:0] bits, input logic [15:0] exp, input int n,
                            input string tag);
        for (int i = n - 1; i >= 0; i--) begin
            bit_in(1'b1, bits[i], exp[i], $sformatf("%s_b%0d", tag, n - i));
        end
    endtask

    task automatic do_reset();
        rst     = 1'b0;
        x_valid = 1'b0;
        x       = 1'b0;
        load    = 1'b0;
        pat_in  = 4'd0;
        clr_cnt = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("rst_y", {31'd0, y}, 32'd0);
        check_val("rst_cnt", 32'(match_cnt), 32'd0);
        check_val("rst_sat", {31'd0, cnt_sat}, 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst     = 1'b0;
        overlap = 1'b1;

        // Overlapping detection of the reset pattern 1010.
        do_reset();
        run_bits(16'b101010, 16'b000101, 6, "ovl");
        check_val("ovl_cnt", 32'(match_cnt), 32'd2);
        check_val("ovl_sat", {31'd0, cnt_sat}, 32'd0);
        check_val("ovl_cnt2", 32'(cnt2), 32'd2);

        // Non-overlapping: restart after each match.
        overlap = 1'b0;
        do_reset();
        run_bits(16'b101010, 16'b000100, 6, "novl");
        check_val("novl_cnt", 32'(match_cnt), 32'd1);
        run_bits(16'b10, 16'b01, 2, "novl_tail");
        check_val("novl_cnt_b", 32'(match_cnt), 32'd2);

        // Load 0110 on a cycle that would have completed 1010.
        overlap = 1'b1;
        do_reset();
        run_bits(16'b101, 16'b000, 3, "pre_ld");
        load    = 1'b1;
        pat_in  = 4'b0110;
        x_valid = 1'b1;
        x       = 1'b0;
        @(negedge clk);
        check_val("load_y", {31'd0, y}, 32'd0);
        @(posedge clk);
        #1;
        load = 1'b0;
        run_bits(16'b0110, 16'b0001, 4, "newpat");
        run_bits(16'b1010, 16'b0000, 4, "oldpat");
        check_val("ld_cnt", 32'(match_cnt), 32'd1);

        // Valid gap: x toggles but must be ignored; reset restores 1010.
        do_reset();
        run_bits(16'b101, 16'b000, 3, "gap_pre");
        bit_in(1'b0, 1'b0, 1'b0, "gap_1");
        bit_in(1'b0, 1'b1, 1'b0, "gap_2");
        bit_in(1'b0, 1'b0, 1'b0, "gap_3");
        bit_in(1'b1, 1'b0, 1'b1, "gap_end");
        check_val("gap_cnt", 32'(match_cnt), 32'd1);

        // Saturation on the 2-bit counter, then a clear on a match cycle.
        do_reset();
        run_bits(16'b10101010, 16'b00010101, 8, "sat_a");
        check_val("sat3_cnt2", 32'(cnt2), 32'd3);
        check_val("sat3_sat2", {31'd0, sat2}, 32'd1);
        check_val("sat3_sat", {31'd0, cnt_sat}, 32'd0);
        run_bits(16'b1010, 16'b0101, 4, "sat_b");
        check_val("sat5_cnt2", 32'(cnt2), 32'd3);
        check_val("sat5_sat2", {31'd0, sat2}, 32'd1);
        check_val("sat5_cnt", 32'(match_cnt), 32'd5);
        bit_in(1'b1, 1'b1, 1'b0, "clr_pre");
        clr_cnt = 1'b1;
        bit_in(1'b1, 1'b0, 1'b1, "clr_y");
        clr_cnt = 1'b0;
        check_val("clr_cnt2", 32'(cnt2), 32'd0);
        check_val("clr_sat2", {31'd0, sat2}, 32'd0);
        check_val("clr_cnt", 32'(match_cnt), 32'd0);
        run_bits(16'b10, 16'b01, 2, "post_clr");
        check_val("post_clr_cnt", 32'(match_cnt), 32'd1);

        // Asynchronous reset mid-stream while the next bit would complete a match.
        do_reset();
        run_bits(16'b101, 16'b000, 3, "ar_pre");
        x_valid = 1'b1;
        x       = 1'b0;
        #1;
        check_val("ar_armed_y", {31'd0, y}, 32'd1);
        rst = 1'b0;
        #1;
        check_val("ar_y", {31'd0, y}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        bit_in(1'b1, 1'b0, 1'b0, "ar_first");
        run_bits(16'b1010, 16'b0001, 4, "ar_refill");
        check_val("ar_cnt", 32'(match_cnt), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
